// File: rtl/frame_writer.sv
// Write side of the double-buffered VGA framebuffer. It writes one frame of
// streamed pixels into the back bank and swaps banks on the next vsync fall.
module frame_writer #(
  parameter int unsigned WIDTH      = 400,
  parameter int unsigned HEIGHT     = 200,
  parameter logic [31:0] BANK0_BASE = 32'd0,
  parameter logic [31:0] BANK1_BASE = 32'd80000
) (
  input  logic        vgaclk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sof,
  input  logic        vsync,
  output logic        we,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] front_base,
  output logic        frame_done,
  output logic        sof_err
);

  localparam logic [16:0] LAST = 17'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_SWAP} state_t;

  state_t      r_state;
  logic [16:0] r_cnt;
  logic        r_front_bank;
  logic        r_vsync_q;

  logic        w_accept;
  logic        w_vsync_fall;
  logic [31:0] w_back_base;

  // Readiness depends only on state, so the producer never waits on its own valid.
  assign in_ready     = (r_state != WAIT_SWAP);
  assign w_accept     = in_valid & in_ready;
  assign w_vsync_fall = r_vsync_q & ~vsync;
  assign w_back_base  = r_front_bank ? BANK0_BASE : BANK1_BASE;
  assign front_base   = r_front_bank ? BANK1_BASE : BANK0_BASE;

  // NOTE: non-blocking assignments throughout, so every branch reads the
  // pre-edge values of r_cnt/r_front_bank regardless of statement order.
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_front_bank <= 1'b0;
      r_vsync_q    <= 1'b1;
      we           <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      frame_done   <= 1'b0;
      sof_err      <= 1'b0;
    end else begin
      r_vsync_q  <= vsync;
      we         <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;

      case (r_state)
        IDLE: begin
          // Beats without sof are dropped until a frame start is seen.
          if (w_accept && in_sof) begin
            we      <= 1'b1;
            wr_addr <= w_back_base;
            wr_data <= in_data;
            r_cnt   <= 17'd1;
            r_state <= WRITE;
          end
        end

        WRITE: begin
          if (w_accept) begin
            we      <= 1'b1;
            wr_data <= in_data;
            if (in_sof) begin
              wr_addr <= w_back_base;
              r_cnt   <= 17'd1;
              sof_err <= 1'b1;
            end else begin
              wr_addr <= w_back_base + 32'(r_cnt);
              if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_state <= WAIT_SWAP;
              end else begin
                r_cnt <= r_cnt + 17'd1;
              end
            end
          end
        end

        WAIT_SWAP: begin
          if (w_vsync_fall) begin
            r_front_bank <= ~r_front_bank;
            frame_done   <= 1'b1;
            r_state      <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer, run with a reduced 8x4 frame so every
// scenario fits in a few hundred cycles.
module tb_frame_writer;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 4;
  localparam int          N  = W * H;
  localparam logic [31:0] B0 = 32'd0;
  localparam logic [31:0] B1 = 32'd80000;

  logic        vgaclk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sof;
  logic        vsync;
  logic        we;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] front_base;
  logic        frame_done;
  logic        sof_err;

  int n_checks = 0;
  int n_pass   = 0;

  frame_writer #(
    .WIDTH(W), .HEIGHT(H), .BANK0_BASE(B0), .BANK1_BASE(B1)
  ) dut (
    .vgaclk(vgaclk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .vsync(vsync), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .front_base(front_base),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 vgaclk = ~vgaclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge vgaclk);
    #1;
  endtask

  task automatic beat(input logic sof, input logic [31:0] data, input logic exp_we,
                      input logic [31:0] exp_addr, input logic exp_ready, input logic exp_err);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check("we", 32'(we), 32'(exp_we));
    if (exp_we) begin
      check("wr_addr", wr_addr, exp_addr);
      check("wr_data", wr_data, data);
    end
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("sof_err", 32'(sof_err), 32'(exp_err));
  endtask

  // Non-sof beats for offsets from..to, data equal to the offset.
  task automatic rest(input logic [31:0] base, input int from, input int to);
    for (int i = from; i <= to; i++)
      beat(1'b0, 32'(i), 1'b1, base + 32'(i), (i != N - 1), 1'b0);
  endtask

  // Offers a beat while parked in WAIT_SWAP, then drops vsync to swap.
  task automatic swap(input logic [31:0] exp_base, input logic [31:0] old_base);
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_data  = 32'hDEAD;
    vsync    = 1'b1;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check("wait_we", 32'(we), 32'd0);
    check("wait_ready", 32'(in_ready), 32'd0);
    check("wait_front", front_base, old_base);
    vsync = 1'b0;
    tick();
    check("swap_front", front_base, exp_base);
    check("swap_done", 32'(frame_done), 32'd1);
    check("swap_ready", 32'(in_ready), 32'd1);
    vsync = 1'b1;
    tick();
    check("done_pulse", 32'(frame_done), 32'd0);
    check("front_hold", front_base, exp_base);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_data  = 32'h1234;
    vsync    = 1'b1;
    tick();
    tick();
    check("rst_we", 32'(we), 32'd0);
    check("rst_front", front_base, B0);
    check("rst_addr", wr_addr, 32'd0);
    check("rst_data", wr_data, 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(sof_err), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check("rst_ready", 32'(in_ready), 32'd1);

    // Idle drop, then a frame into bank 1 starting with data 0xAA.
    for (int i = 0; i < 5; i++) beat(1'b0, 32'(100 + i), 1'b0, 32'd0, 1'b1, 1'b0);
    beat(1'b1, 32'hAA, 1'b1, B1, 1'b1, 1'b0);
    rest(B1, 1, N - 1);
    swap(B1, B0);

    // Second frame lands in bank 0 and swaps back.
    beat(1'b1, 32'd0, 1'b1, B0, 1'b1, 1'b0);
    rest(B0, 1, N - 1);
    swap(B0, B1);

    // Mid-frame sof restart, vsync fall during WRITE, last pixel with vsync fall.
    beat(1'b1, 32'd0, 1'b1, B1, 1'b1, 1'b0);
    rest(B1, 1, 9);
    beat(1'b1, 32'h55, 1'b1, B1, 1'b1, 1'b1);
    rest(B1, 1, 4);
    vsync = 1'b0;
    rest(B1, 5, 5);
    check("wr_vs_done", 32'(frame_done), 32'd0);
    check("wr_vs_front", front_base, B0);
    vsync = 1'b1;
    rest(B1, 6, N - 2);
    vsync = 1'b0;
    rest(B1, N - 1, N - 1);
    check("last_vs_done", 32'(frame_done), 32'd0);
    check("last_vs_front", front_base, B0);
    tick();
    check("last_vs_hold", 32'(frame_done), 32'd0);
    swap(B1, B0);

    // Reset while parked in WAIT_SWAP, with vsync falling on the same edge.
    beat(1'b1, 32'd7, 1'b1, B0, 1'b1, 1'b0);
    rest(B0, 1, N - 1);
    check("pre_rst_front", front_base, B1);
    rst   = 1'b1;
    vsync = 1'b0;
    tick();
    rst = 1'b0;
    check("rst2_front", front_base, B0);
    check("rst2_done", 32'(frame_done), 32'd0);
    check("rst2_ready", 32'(in_ready), 32'd1);
    check("rst2_we", 32'(we), 32'd0);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    check("idle_vs_done", 32'(frame_done), 32'd0);
    check("idle_vs_front", front_base, B0);
    vsync = 1'b1;
    beat(1'b1, 32'h77, 1'b1, B1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Write-side companion to the VGA scan-out path. Accepts a 32-bit pixel stream over a valid/ready handshake and writes one 400x200 frame into the back bank of a double-buffered framebuffer. At the start of the next vertical sync pulse it swaps banks, so the VGA address generator always reads a complete frame with no tearing. It sits between the pixel producer (CPU/filter output) and the framebuffer write port, and publishes the current front-bank base address to the scan-out logic.

## Interface
- WIDTH, 400, active pixels per line
- HEIGHT, 200, active lines per frame
- BANK0_BASE, 0, word address of bank 0
- BANK1_BASE, 80000, word address of bank 1
- vgaclk  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  pixel beat valid
- in_ready  out  1  block can accept a beat; combinational from state
- in_data  in  32  pixel value
- in_sof  in  1  beat is the first pixel of a frame
- vsync  in  1  VGA vsync, active-low, from vgaController
- we  out  1  framebuffer write enable, registered
- wr_addr  out  32  framebuffer word address, registered
- wr_data  out  32  framebuffer write data, registered
- front_base  out  32  base address the scan-out must read from (BANK0_BASE or BANK1_BASE)
- frame_done  out  1  one-cycle pulse after each bank swap
- sof_err  out  1  one-cycle pulse when `in_sof` arrives mid-frame

## Operation
- The frame holds N = WIDTH*HEIGHT pixels (80000 at defaults). The pixel counter `cnt` is 17 bits wide and ranges 0..N-1.
- `front_bank` is 1 bit. The back bank is `~front_bank`. `back_base` is BANK1_BASE when the back bank is 1, otherwise BANK0_BASE.
- Write address is `wr_addr = back_base + cnt`, computed as a 32-bit unsigned sum with no wrap.
- A beat is accepted when `in_valid & in_ready`.
- The state machine has three states: IDLE, WRITE, WAIT_SWAP.
- **IDLE:** `in_ready` = 1.
  - An accepted beat with `in_sof` = 0 is dropped: no write, and `sof_err` stays 0.
  - An accepted beat with `in_sof` = 1 is written at offset 0. Then `cnt` becomes 1 and the state moves to WRITE.
- **WRITE:** `in_ready` = 1.
  - An accepted beat with `in_sof` = 0 is written at offset `cnt`, then `cnt` increments.
  - When the written offset is N-1, `cnt` clears to 0 and the state moves to WAIT_SWAP.
  - An accepted beat with `in_sof` = 1 restarts the frame. It is written at offset 0, `cnt` becomes 1, `sof_err` pulses, and the state stays WRITE.
- **WAIT_SWAP:** `in_ready` = 0, so no beats are accepted.
  - On a vsync falling edge (`vsync_q` = 1 & `vsync` = 0, where `vsync_q` is vsync registered once), `front_bank` toggles, `frame_done` pulses, and the state moves to IDLE.
- A vsync falling edge seen in IDLE or WRITE has no effect. Scan-out keeps the old front bank.
- `front_base` is BANK1_BASE when `front_bank` is 1, otherwise BANK0_BASE. It changes only on a swap.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `front_bank` 0, `vsync_q` 1.
  - Outputs: `we` 0, `wr_addr` 0, `wr_data` 0, `frame_done` 0, `sof_err` 0, `front_base` BANK0_BASE.
  - `in_ready` is 1 in the first cycle after reset.
- **Write latency:** a beat accepted at edge k drives `we` = 1 with its address and data during the cycle after edge k. `we` = 0 in every cycle that follows an edge with no accepted beat that writes.
- **Throughput:** one pixel per cycle sustained in WRITE.
- **Last pixel:** accepted at edge k, so `we` is high for offset N-1 after edge k, and `in_ready` = 0 from edge k onward.
- **Swap:** the falling edge is sampled at edge m in WAIT_SWAP.
  - After edge m: `front_base` is updated, `frame_done` = 1 for exactly one cycle, and `in_ready` = 1.
  - Vsync is asynchronous-safe only if it comes from the same vgaclk domain, which it does.
- **Last pixel and vsync fall in the same cycle:** there is no swap. The block waits for the next vsync fall.
- **`sof_err`:** high in the cycle after the offending beat is accepted, together with `we` for offset 0.
- **Reset mid-frame or during WAIT_SWAP:** all state returns to reset values on the next edge. `front_bank` returns to 0 and the partial frame is abandoned.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid` = 1 -> `we` = 0, `front_base` = 0, `in_ready` = 1 after release.
- **Full frame:** stream 80000 beats (sof on the first beat, data = index), then drop vsync.
  - Expect writes at addresses 80000..159999 with data 0..79999 and `in_ready` = 0 after the last beat.
  - On the vsync fall, expect `front_base` = 80000 and a single-cycle `frame_done`.
- **Second frame:** repeat the full frame -> writes at 0..79999, `front_base` returns to 0 on the next vsync fall.
- **Idle drop:** 5 beats with `in_sof` = 0, then a sof beat with data 0xAA -> no writes for the first 5, then `we` with `wr_addr` = 80000 and `wr_data` = 0xAA.
- **Mid-frame sof:** after 100 pixels, send `in_sof` = 1 -> `sof_err` pulse, next write at 80000, frame completes only after 80000 further beats.
- **Edge cases:** a vsync fall during WRITE and a vsync fall on the same edge as the last pixel -> no swap in either case, swap on the subsequent fall. `rst` in WAIT_SWAP -> `front_base` = 0 and no `frame_done`.
